// File: rtl/mem_access_ctrl.sv
// Load/store data-memory access controller: one request at a time onto a word-addressed,
// byte-enabled bus with ack handshake, plus misalignment rejection and bus timeout abort.
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        reqValid,
   output logic        reqReady,
   input  logic [31:0] reqAddr,
   input  logic [31:0] reqWdata,
   input  logic [1:0]  memOp,
   input  logic [1:0]  memSize,
   output logic        busReq,
   output logic        busWe,
   output logic [31:0] busAddr,
   output logic [31:0] busWdata,
   output logic [3:0]  busBe,
   input  logic        busAck,
   input  logic [31:0] busRdata,
   output logic [31:0] addr,
   output logic [31:0] rawDout,
   output logic        readValid,
   output logic [1:0]  memOpOut,
   output logic [1:0]  memSizeOut,
   output logic        storeDone,
   output logic        misalign,
   output logic        timeout
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_STORE = 2'b10;
   localparam logic [1:0] SZ_BYTE  = 2'b00;
   localparam logic [1:0] SZ_HALF  = 2'b01;
   localparam logic [1:0] SZ_WORD  = 2'b10;
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = lo[0];
         SZ_WORD: bad = (lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lo);
      logic [3:0] be;
      case (size)
         SZ_BYTE: be = 4'b0001 << lo;
         SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // Stores replicate the datum across every lane it could occupy; loads drive zero.
   function automatic logic [31:0] store_data(input logic [1:0] op, input logic [1:0] size,
                                              input logic [31:0] wdata);
      logic [31:0] d;
      if (op != OP_STORE) begin
         d = 32'h0000_0000;
      end else begin
         case (size)
            SZ_BYTE: d = {4{wdata[7:0]}};
            SZ_HALF: d = {2{wdata[15:0]}};
            SZ_WORD: d = wdata;
            default: d = 32'h0000_0000;
         endcase
      end
      return d;
   endfunction

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  op_q, op_d;
   logic [1:0]  size_q, size_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic [31:0] raw_q, raw_d;
   logic        req_ready_q, req_ready_d;
   logic        bus_req_q, bus_req_d;
   logic        read_valid_q, read_valid_d;
   logic        store_done_q, store_done_d;
   logic        misalign_q, misalign_d;
   logic        timeout_q, timeout_d;
   logic        accept_s;
   logic        op_valid_s;

   assign op_valid_s = (memOp == OP_LOAD) || (memOp == OP_STORE);
   assign accept_s   = reqValid && (state_q == ST_IDLE) && op_valid_s;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               state_d = is_misaligned(memSize, reqAddr[1:0]) ? ST_ERR : ST_BUS;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUS: begin
            if (busAck) begin
               state_d = (op_q == OP_LOAD) ? ST_RESP : ST_IDLE;
            end else if (cnt_q == WAIT_LAST) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_BUS;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output decode; every output is registered so it follows the state it belongs to
   always_comb begin
      req_ready_d  = (state_d == ST_IDLE);
      bus_req_d    = (state_d == ST_BUS);
      read_valid_d = (state_d == ST_RESP);
      misalign_d   = (state_d == ST_ERR);
      store_done_d = (state_q == ST_BUS) && busAck && (op_q == OP_STORE);
      timeout_d    = (state_q == ST_BUS) && !busAck && (cnt_q == WAIT_LAST);
   end

   // Request capture, wait counter and read-data capture
   always_comb begin
      addr_d  = addr_q;
      op_d    = op_q;
      size_d  = size_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      raw_d   = raw_q;
      cnt_d   = cnt_q;
      if (accept_s) begin
         addr_d  = reqAddr;
         op_d    = memOp;
         size_d  = memSize;
         be_d    = byte_enables(memSize, reqAddr[1:0]);
         wdata_d = store_data(memOp, memSize, reqWdata);
         we_d    = (memOp == OP_STORE);
         cnt_d   = 8'd0;
      end else if (state_q == ST_BUS) begin
         if (busAck) begin
            raw_d = (op_q == OP_LOAD) ? busRdata : raw_q;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= 8'd0;
         addr_q  <= 32'h0000_0000;
         op_q    <= 2'b00;
         size_q  <= 2'b00;
         be_q    <= 4'b0000;
         wdata_q <= 32'h0000_0000;
         we_q    <= 1'b0;
         raw_q   <= 32'h0000_0000;
      end else begin
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         op_q    <= op_d;
         size_q  <= size_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         raw_q   <= raw_d;
      end
   end

   // Control output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_ready_q  <= 1'b1;
         bus_req_q    <= 1'b0;
         read_valid_q <= 1'b0;
         store_done_q <= 1'b0;
         misalign_q   <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         req_ready_q  <= req_ready_d;
         bus_req_q    <= bus_req_d;
         read_valid_q <= read_valid_d;
         store_done_q <= store_done_d;
         misalign_q   <= misalign_d;
         timeout_q    <= timeout_d;
      end
   end

   assign reqReady   = req_ready_q;
   assign busReq     = bus_req_q;
   assign busWe      = we_q;
   assign busAddr    = {addr_q[31:2], 2'b00};
   assign busWdata   = wdata_q;
   assign busBe      = be_q;
   assign addr       = addr_q;
   assign rawDout    = raw_q;
   assign readValid  = read_valid_q;
   assign memOpOut   = op_q;
   assign memSizeOut = size_q;
   assign storeDone  = store_done_q;
   assign misalign   = misalign_q;
   assign timeout    = timeout_q;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Data-memory access controller for the load/store stage, sitting directly upstream of the memory output logic. Accepts one load or store request at a time from the pipeline and drives a word-addressed, byte-enabled data bus with an ack handshake. Forwards the raw read word, together with the original byte address, op and size, to the output logic as a one-cycle read-valid pulse. Flags misaligned accesses and bus timeouts without touching the bus.

## Interface
- TIMEOUT_CYCLES, 255: number of cycles in BUS without busAck before aborting; range 1–255.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- reqValid  in  1  pipeline request valid.
- reqReady  out  1  request can be accepted; high only in IDLE.
- reqAddr  in  32  byte address.
- reqWdata  in  32  store data, right-justified.
- memOp  in  2  00 none, 01 load, 10 store, 11 none.
- memSize  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned).
- busReq  out  1  bus request, held until ack or timeout.
- busWe  out  1  1 = write.
- busAddr  out  32  {reqAddr[31:2], 2'b00}.
- busWdata  out  32  replicated store data.
- busBe  out  4  byte enables.
- busAck  in  1  bus completion; sampled only in BUS.
- busRdata  in  32  read word; valid in the busAck cycle.
- addr  out  32  original byte address of the returning load.
- rawDout  out  32  captured read word.
- readValid  out  1  one-cycle pulse; load data valid.
- memOpOut  out  2  op of the returning access.
- memSizeOut  out  2  size of the returning access.
- storeDone  out  1  one-cycle pulse; store acked.
- misalign  out  1  one-cycle pulse; request rejected.
- timeout  out  1  one-cycle pulse; bus access aborted.

## Operation
- States: IDLE, BUS, RESP, ERR.
- Accept: reqValid & reqReady & memOp ∈ {01,10}. Requests with memOp 00/11 are ignored and produce no response.
- On accept, register address, op, size, byte enables and write data.
- Alignment rule: misaligned means half with addr[0]=1, word with addr[1:0]≠0, or size 11.
  - Aligned request: IDLE→BUS.
  - Misaligned request: IDLE→ERR.
- ERR: misalign=1 for one cycle, then →IDLE. busReq never asserted.
- Byte enables:
  - byte: 4'b0001 << addr[1:0].
  - half: addr[1]=0 → 0011, addr[1]=1 → 1100.
  - word: 1111.
- Write data:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
  - For loads, busWdata is 0.
- BUS: busReq=1. busWe/busAddr/busBe/busWdata are held stable. An 8-bit wait counter starts at 0 on entry and increments each cycle without ack.
  - busAck=1, load: capture busRdata, →RESP.
  - busAck=1, store: storeDone=1 in the cycle after ack, →IDLE.
  - Counter reaches TIMEOUT_CYCLES−1 with no ack: →IDLE and timeout=1 the next cycle. busAck is ignored after abort.
- RESP: readValid=1 for one cycle, with rawDout/addr/memOpOut/memSizeOut valid; then →IDLE.
- rawDout, addr, memOpOut, memSizeOut hold their last values until the next accept.
- busAck outside BUS is ignored.
- No sign extension or byte lane selection happens here; that belongs to downstream logic.

## Timing
- Reset (async, immediate): state IDLE, counter 0. Every output is 0 except reqReady=1 once in IDLE; busReq drops combinationally with rst.
- Zero-wait load: accept edge E0 → busReq high in cycle E0+1 with ack → readValid in cycle E0+2 → reqReady=1 in cycle E0+3.
- Load latency is 2 + N cycles for N wait states. Store done pulse is at the same position as readValid.
- Misaligned: misalign pulse in cycle E0+1; reqReady=1 in cycle E0+2.
- Timeout: busReq is high for exactly TIMEOUT_CYCLES cycles; timeout pulse follows in the next cycle, coincident with reqReady=1.
- Pulse exclusivity: at most one of readValid, storeDone, misalign, timeout is high in any cycle.
- Reset mid-access abandons the transaction; no response pulse follows.

## Test plan
- Word load at 0x100, ack in first BUS cycle, busRdata=0xDEADBEEF → busAddr=0x100, busBe=1111, busWe=0; readValid one cycle at E0+2 with rawDout=0xDEADBEEF, addr=0x100, memSizeOut=10.
- Byte store at 0x203, wdata=0x000000A5, ack after 3 wait states → busAddr=0x200, busBe=1000, busWdata=0xA5A5A5A5 stable for 4 cycles; storeDone at E0+5; readValid never asserted.
- Half load at 0x101 → busReq stays 0, misalign pulse at E0+1, reqReady=1 at E0+2. Word at 0x102 and size 11 give the same response.
- TIMEOUT_CYCLES=4, store at 0x40, busAck held 0 → busReq high exactly 4 cycles, timeout pulse next cycle. A late busAck after abort produces no storeDone.
- rst asserted mid-BUS with busReq=1 → busReq=0 same cycle, all pulses 0. After release, reqReady=1, and a new word load at 0x8 completes normally.
- Back-to-back loads with reqValid held high → accepts spaced 3 cycles apart. Request with memOp=00 → no bus activity, no pulses, reqReady stays 1.
